// File: rtl/stdp_spike_timer_if.sv
// Event bus of the STDP spike timer: spike/tick inputs toward the timer and
// the buffered t_change event stream (valid/ready) toward the weight-update stage.
interface stdp_spike_timer_if #(
    parameter int N = 32
);
    logic         tick;
    logic         pre_spike;
    logic         post_spike;
    logic         out_ready;
    logic         out_valid;
    logic [N-1:0] t_change;
    logic         is_pos;
    logic         overflow;

    // Timer side: consumes spikes/ticks and the downstream ready, produces events.
    modport master (
        input  tick,
        input  pre_spike,
        input  post_spike,
        input  out_ready,
        output out_valid,
        output t_change,
        output is_pos,
        output overflow
    );

    // Environment side: drives spikes/ticks and ready, consumes events.
    modport slave (
        output tick,
        output pre_spike,
        output post_spike,
        output out_ready,
        input  out_valid,
        input  t_change,
        input  is_pos,
        input  overflow
    );
endinterface

// File: rtl/stdp_spike_timer.sv
// STDP spike timer: tracks time since the last pre- and post-synaptic spikes
// and, on each pairing, queues a sign-magnitude fixed-point t_change event
// (positive = LTP, negative = LTD) into a 2-entry FIFO with valid/ready output.
module stdp_spike_timer #(
    parameter int             N  = 32,
    parameter int             Q  = 16,
    parameter logic [N-1:0]   DT = 32'h0000_1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stdp_spike_timer_if.master   bus
);

    localparam int          M        = N - 1;
    localparam logic [M-1:0] DT_MAG  = DT[M-1:0];
    localparam logic [M-1:0] MAG_MAX = {M{1'b1}};

    // Elaboration-time sanity of the fixed-point format and increment sign.
    if (Q >= N) begin : g_bad_q
        $error("stdp_spike_timer: Q must be smaller than N");
    end
    if (DT[N-1] != 1'b0) begin : g_bad_dt
        $error("stdp_spike_timer: DT must be a positive magnitude");
    end

    // Saturating add of the time increment; counters stick at all-ones.
    function automatic logic [M-1:0] sat_add(input logic [M-1:0] a);
        logic [M:0] s;
        s = {1'b0, a} + {1'b0, DT_MAG};
        if (s[M]) begin
            sat_add = MAG_MAX;
        end else begin
            sat_add = s[M-1:0];
        end
    endfunction

    // Time counters and "spike seen" flags.
    logic [M-1:0] since_pre_q,  since_pre_d;
    logic [M-1:0] since_post_q, since_post_d;
    logic         pre_seen_q,   pre_seen_d;
    logic         post_seen_q,  post_seen_d;

    // FIFO: head entry drives the outputs, tail is the second slot.
    logic         head_valid_q, head_valid_d;
    logic         head_pos_q,   head_pos_d;
    logic [N-1:0] head_tc_q,    head_tc_d;
    logic         tail_valid_q, tail_valid_d;
    logic         tail_pos_q,   tail_pos_d;
    logic [N-1:0] tail_tc_q,    tail_tc_d;
    logic         overflow_q,   overflow_d;

    // Event produced this cycle.
    logic         ev_valid_s;
    logic         ev_pos_s;
    logic [N-1:0] ev_tc_s;
    logic         pop_s;

    // Counter/flag update: a spike clears its counter and wins over a tick.
    always_comb begin
        since_pre_d  = since_pre_q;
        since_post_d = since_post_q;
        pre_seen_d   = pre_seen_q;
        post_seen_d  = post_seen_q;
        if (bus.pre_spike) begin
            since_pre_d = '0;
            pre_seen_d  = 1'b1;
        end else if (bus.tick) begin
            since_pre_d = sat_add(since_pre_q);
        end else begin
            since_pre_d = since_pre_q;
        end
        if (bus.post_spike) begin
            since_post_d = '0;
            post_seen_d  = 1'b1;
        end else if (bus.tick) begin
            since_post_d = sat_add(since_post_q);
        end else begin
            since_post_d = since_post_q;
        end
    end

    // Event generation from pre-update counter values; at most one per cycle.
    always_comb begin
        ev_valid_s = 1'b0;
        ev_pos_s   = 1'b0;
        ev_tc_s    = '0;
        if (bus.pre_spike && bus.post_spike) begin
            // Coincident spikes count as a zero-delay LTP pairing.
            ev_valid_s = 1'b1;
            ev_pos_s   = 1'b1;
            ev_tc_s    = '0;
        end else if (bus.post_spike && pre_seen_q) begin
            ev_valid_s = 1'b1;
            ev_pos_s   = 1'b1;
            ev_tc_s    = {1'b0, since_pre_q};
        end else if (bus.pre_spike && post_seen_q) begin
            ev_valid_s = 1'b1;
            ev_pos_s   = 1'b0;
            // Zero magnitude is emitted with a positive sign (no negative zero).
            if (since_post_q == '0) begin
                ev_tc_s = '0;
            end else begin
                ev_tc_s = {1'b1, since_post_q};
            end
        end else begin
            ev_valid_s = 1'b0;
        end
    end

    assign pop_s = head_valid_q & bus.out_ready;

    // FIFO next state: pop first (frees a slot), then push into the first free slot.
    always_comb begin
        head_valid_d = head_valid_q;
        head_pos_d   = head_pos_q;
        head_tc_d    = head_tc_q;
        tail_valid_d = tail_valid_q;
        tail_pos_d   = tail_pos_q;
        tail_tc_d    = tail_tc_q;
        overflow_d   = overflow_q;

        if (pop_s) begin
            if (tail_valid_q) begin
                head_valid_d = 1'b1;
                head_pos_d   = tail_pos_q;
                head_tc_d    = tail_tc_q;
                tail_valid_d = 1'b0;
            end else begin
                // Head data keeps its last value while empty.
                head_valid_d = 1'b0;
            end
        end else begin
            head_valid_d = head_valid_q;
        end

        if (ev_valid_s) begin
            if (!head_valid_d) begin
                head_valid_d = 1'b1;
                head_pos_d   = ev_pos_s;
                head_tc_d    = ev_tc_s;
            end else if (!tail_valid_d) begin
                tail_valid_d = 1'b1;
                tail_pos_d   = ev_pos_s;
                tail_tc_d    = ev_tc_s;
            end else begin
                // Both slots still occupied: drop and remember it.
                overflow_d = 1'b1;
            end
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State registers; asynchronous reset discards everything pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            since_pre_q  <= '0;
            since_post_q <= '0;
            pre_seen_q   <= 1'b0;
            post_seen_q  <= 1'b0;
            head_valid_q <= 1'b0;
            head_pos_q   <= 1'b0;
            head_tc_q    <= '0;
            tail_valid_q <= 1'b0;
            tail_pos_q   <= 1'b0;
            tail_tc_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            since_pre_q  <= since_pre_d;
            since_post_q <= since_post_d;
            pre_seen_q   <= pre_seen_d;
            post_seen_q  <= post_seen_d;
            head_valid_q <= head_valid_d;
            head_pos_q   <= head_pos_d;
            head_tc_q    <= head_tc_d;
            tail_valid_q <= tail_valid_d;
            tail_pos_q   <= tail_pos_d;
            tail_tc_q    <= tail_tc_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.out_valid = head_valid_q;
    assign bus.t_change  = head_tc_q;
    assign bus.is_pos    = head_pos_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_stdp_spike_timer.sv
// Scoreboard bench for stdp_spike_timer: directed spike/tick sequences push
// hand-computed events into per-DUT queues; a negedge monitor pops and compares
// on every accepted handshake. DUT A uses DT=0x1000, DUT B DT=0x4000_0000.
module tb_stdp_spike_timer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stdp_spike_timer_if #(.N(32)) ifa ();
    stdp_spike_timer_if #(.N(32)) ifb ();

    stdp_spike_timer #(.N(32), .Q(16), .DT(32'h0000_1000)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.master)
    );

    stdp_spike_timer #(.N(32), .Q(16), .DT(32'h4000_0000)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.master)
    );

    logic [32:0] qa[$];
    logic [32:0] qb[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted head event against the scoreboard.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && ifa.out_valid && ifa.out_ready) begin
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL unexpected_a: got pos=%0b tc=%h, required no event", ifa.is_pos, ifa.t_change);
            end else begin
                e = qa.pop_front();
                if ({ifa.is_pos, ifa.t_change} !== e) begin
                    bad++;
                    $display("FAIL event_a: got pos=%0b tc=%h, required pos=%0b tc=%h",
                             ifa.is_pos, ifa.t_change, e[32], e[31:0]);
                end
            end
        end
        if (rst_n && ifb.out_valid && ifb.out_ready) begin
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_b: got pos=%0b tc=%h, required no event", ifb.is_pos, ifb.t_change);
            end else begin
                e = qb.pop_front();
                if ({ifb.is_pos, ifb.t_change} !== e) begin
                    bad++;
                    $display("FAIL event_b: got pos=%0b tc=%h, required pos=%0b tc=%h",
                             ifb.is_pos, ifb.t_change, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic step_a(input logic t, input logic p, input logic s);
        ifa.tick = t; ifa.pre_spike = p; ifa.post_spike = s;
        @(posedge clk); #1;
        ifa.tick = 1'b0; ifa.pre_spike = 1'b0; ifa.post_spike = 1'b0;
    endtask

    task automatic step_b(input logic t, input logic p, input logic s);
        ifb.tick = t; ifb.pre_spike = p; ifb.post_spike = s;
        @(posedge clk); #1;
        ifb.tick = 1'b0; ifb.pre_spike = 1'b0; ifb.post_spike = 1'b0;
    endtask

    task automatic ticks_a(input int n);
        for (int i = 0; i < n; i++) step_a(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        ifa.tick = 1'b0; ifa.pre_spike = 1'b0; ifa.post_spike = 1'b0; ifa.out_ready = 1'b1;
        ifb.tick = 1'b0; ifb.pre_spike = 1'b0; ifb.post_spike = 1'b0; ifb.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_valid", {31'd0, ifa.out_valid}, 32'd0);
        check("rst_tc",    ifa.t_change,           32'h0000_0000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_pos", {31'd0, ifa.is_pos},   32'd0);
        check("post_rst_ovf", {31'd0, ifa.overflow}, 32'd0);

        // First post with no prior pre: no event
        step_a(1'b0, 1'b0, 1'b1);
        check("first_post_no_event", {31'd0, ifa.out_valid}, 32'd0);

        // pre right after post: LTD with zero magnitude, positive sign
        qa.push_back({1'b0, 32'h0000_0000});
        step_a(1'b0, 1'b1, 1'b0);
        check("ltd_zero_latency", {31'd0, ifa.out_valid}, 32'd1);

        // 16 ticks after pre, then post: LTP 1.0
        ticks_a(16);
        qa.push_back({1'b1, 32'h0001_0000});
        step_a(1'b0, 1'b0, 1'b1);
        check("ltp_latency", {31'd0, ifa.out_valid}, 32'd1);

        // 8 ticks after post, then pre: LTD -0.5
        ticks_a(8);
        qa.push_back({1'b0, 32'h8000_8000});
        step_a(1'b0, 1'b1, 1'b0);

        // Coincident spikes with tick: single zero LTP
        qa.push_back({1'b1, 32'h0000_0000});
        step_a(1'b1, 1'b1, 1'b1);
        step_a(1'b0, 1'b0, 1'b0);
        check("single_event", {31'd0, ifa.out_valid}, 32'd0);

        // Stall: three LTP events, third dropped
        ifa.out_ready = 1'b0;
        ticks_a(1);
        qa.push_back({1'b1, 32'h0000_1000});
        step_a(1'b0, 1'b0, 1'b1);
        check("stall_head_tc", ifa.t_change, 32'h0000_1000);
        ticks_a(1);
        qa.push_back({1'b1, 32'h0000_2000});
        step_a(1'b0, 1'b0, 1'b1);
        check("stall_hold_tc", ifa.t_change, 32'h0000_1000);
        check("ovf_before_drop", {31'd0, ifa.overflow}, 32'd0);
        ticks_a(1);
        step_a(1'b0, 1'b0, 1'b1);  // 0x3000 dropped
        check("ovf_after_drop", {31'd0, ifa.overflow}, 32'd1);
        check("stall_hold_tc2", ifa.t_change, 32'h0000_1000);
        check("stall_hold_pos", {31'd0, ifa.is_pos}, 32'd1);

        // Full + pop in the same cycle: new event accepted
        ifa.out_ready = 1'b1;
        qa.push_back({1'b1, 32'h0000_3000});
        step_a(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b0, 1'b0);
        check("drained_valid", {31'd0, ifa.out_valid}, 32'd0);
        check("drained_queue", qa.size(), 32'd0);

        // Mid-cycle reset with a stalled event pending
        ifa.out_ready = 1'b0;
        step_a(1'b0, 1'b0, 1'b1);
        check("pending_valid", {31'd0, ifa.out_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, ifa.out_valid}, 32'd0);
        check("async_rst_tc",    ifa.t_change,           32'h0000_0000);
        check("async_rst_pos",   {31'd0, ifa.is_pos},    32'd0);
        check("async_rst_ovf",   {31'd0, ifa.overflow},  32'd0);
        qa.delete();
        qb.delete();
        #3 rst_n = 1'b1;
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        step_a(1'b0, 1'b0, 1'b1);
        check("post_after_rst_no_event", {31'd0, ifa.out_valid}, 32'd0);
        step_a(1'b0, 1'b0, 1'b0);

        // Saturation on DUT B
        step_b(1'b0, 1'b1, 1'b0);
        check("b_first_pre_no_event", {31'd0, ifb.out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) step_b(1'b1, 1'b0, 1'b0);
        qb.push_back({1'b1, 32'h7FFF_FFFF});
        step_b(1'b0, 1'b0, 1'b1);
        check("b_sat_tc", ifb.t_change, 32'h7FFF_FFFF);
        step_b(1'b0, 1'b0, 1'b0);
        step_b(1'b0, 1'b0, 1'b0);

        check("final_queue_a", qa.size(), 32'd0);
        check("final_queue_b", qb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
